// File: rtl/pmt_communication_rx_if.sv
// rtl/pmt_communication_rx_if.sv - link pins and word/status outputs of pmt_communication_rx
//
// Purpose: bundles the forwarded link pair (RX_CLK/RX_DATA) with the
// receiver's word, error and counter outputs.
// Signals:
//   RX_CLK       link clock, idles high, toggles only during a word
//   RX_DATA      link data, MSB first, stable at RX_CLK falling edges
//   rx_vld_o     one-cycle pulse, rx_data_o holds a new word
//   rx_data_o    last complete word
//   rx_err_o     one-cycle pulse, word aborted on timeout
//   rx_busy_o    word partially received
//   frame_cnt_o  good-word count, wrapping
//   err_cnt_o    aborted-word count, saturating
// Modports:
//   master  link driver / consumer side (drives the pins, reads results)
//   slave   receiver side
interface pmt_communication_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  RX_CLK;
  logic                  RX_DATA;
  logic                  rx_vld_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_err_o;
  logic                  rx_busy_o;
  logic [15:0]           frame_cnt_o;
  logic [7:0]            err_cnt_o;

  modport master (
    output RX_CLK, RX_DATA,
    input  rx_vld_o, rx_data_o, rx_err_o, rx_busy_o, frame_cnt_o, err_cnt_o
  );

  modport slave (
    input  RX_CLK, RX_DATA,
    output rx_vld_o, rx_data_o, rx_err_o, rx_busy_o, frame_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/pmt_communication_rx.sv
// rtl/pmt_communication_rx.sv - oversampling serial receiver for the pmt_communication link
//
// Purpose: synchronises the forwarded link clock and data into clk_i,
// shifts in DATA_WIDTH-bit words MSB first on link falling edges, and
// reports each word as a one-cycle pulse with framing-timeout detection
// and good/aborted word counters.
// Ports:
//   clk_i    receiver clock, at least 2x the link clock
//   rst_n_i  asynchronous active-low reset
//   bus      pmt_communication_rx_if.slave (link pins in, word/status out)
module pmt_communication_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int IDLE_CYC    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  pmt_communication_rx_if.slave  bus
);

  localparam int BitCntW  = $clog2(DATA_WIDTH);
  localparam int ToCntW   = $clog2(TIMEOUT_CYC + 1);
  localparam int IdleCntW = $clog2(IDLE_CYC + 1);

  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_RECV
  } state_t;

  // Clock and data share one synchroniser depth so the data bit is valid
  // in exactly the cycle the falling edge is seen.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_d;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  state_t                 state_q,    state_d;
  logic [BitCntW-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [ToCntW-1:0]      to_cnt_q,   to_cnt_d;
  logic [IdleCntW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q,    shift_d;
  logic [DATA_WIDTH-1:0]  data_q,     data_d;
  logic                   vld_q,      vld_d;
  logic                   err_q,      err_d;
  logic [15:0]            fcnt_q,     fcnt_d;
  logic [7:0]             ecnt_q,     ecnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_d    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.RX_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.RX_DATA};
      clk_d    <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_d & ~clk_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_ARM;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      idle_cnt_q <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      fcnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      fcnt_q     <= fcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    idle_cnt_d = '0;
    shift_d    = shift_q;
    data_d     = data_q;
    vld_d      = 1'b0;
    err_d      = 1'b0;
    fcnt_d     = fcnt_q;
    ecnt_d     = ecnt_q;

    case (state_q)
      // Wait for a run of link-idle cycles so a reset or error released in
      // the middle of a word never locks onto the tail of that word.
      ST_ARM: begin
        if (idle_cnt_q == IdleCntW'(IDLE_CYC)) begin
          state_d = ST_IDLE;
        end else if (clk_s) begin
          idle_cnt_d = idle_cnt_q + IdleCntW'(1);
        end
      end

      ST_IDLE: begin
        if (fall) begin
          shift_d   = {{(DATA_WIDTH-1){1'b0}}, dat_s};
          bit_cnt_d = BitCntW'(1);
          to_cnt_d  = '0;
          state_d   = ST_RECV;
        end
      end

      ST_RECV: begin
        // A fall arriving on the last tolerated cycle still counts.
        if (fall) begin
          shift_d  = {shift_q[DATA_WIDTH-2:0], dat_s};
          to_cnt_d = '0;
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            data_d    = shift_d;
            vld_d     = 1'b1;
            fcnt_d    = fcnt_q + 16'd1;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end else if (to_cnt_q == ToCntW'(TIMEOUT_CYC)) begin
          err_d     = 1'b1;
          if (ecnt_q != 8'hFF) begin
            ecnt_d = ecnt_q + 8'd1;
          end
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = ST_ARM;
        end else begin
          to_cnt_d = to_cnt_q + ToCntW'(1);
        end
      end

      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  assign bus.rx_vld_o    = vld_q;
  assign bus.rx_data_o   = data_q;
  assign bus.rx_err_o    = err_q;
  assign bus.rx_busy_o   = (state_q == ST_RECV);
  assign bus.frame_cnt_o = fcnt_q;
  assign bus.err_cnt_o   = ecnt_q;

endmodule

// File: tb/tb_pmt_communication_rx.sv
// tb/tb_pmt_communication_rx.sv - randomized self-checking bench for pmt_communication_rx
module tb_pmt_communication_rx;

  localparam int DW   = 16;
  localparam int SYNC = 2;
  localparam int TO   = 64;
  localparam int IDLE = 8;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state: expected events with their cycle stamps, and the
  // expected values of the held outputs.
  ev_t         exp_vld[$];
  ev_t         obs_vld[$];
  int          exp_err[$];
  int          obs_err[$];
  int          falls[$];
  logic [15:0] exp_data = '0;
  logic [15:0] exp_fcnt = '0;
  int          exp_ecnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmt_communication_rx_if #(.DATA_WIDTH(DW)) bus ();

  pmt_communication_rx #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SYNC),
    .TIMEOUT_CYC (TO),
    .IDLE_CYC    (IDLE)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always @(negedge clk) begin
    ev_t e;
    if (bus.rx_vld_o === 1'b1) begin
      e.cyc  = cyc;
      e.data = bus.rx_data_o;
      obs_vld.push_back(e);
    end
    if (bus.rx_err_o === 1'b1) obs_err.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic c, input logic d);
    @(posedge clk);
    #1;
    bus.RX_CLK  = c;
    bus.RX_DATA = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, bus.RX_DATA);
  endtask

  // Sends the top nbits of w MSB first. lo/hi of 0 pick a random phase of
  // 2..4 cycles per bit; bit s_idx gets s_hi extra high cycles before its fall.
  task automatic send_bits(input logic [15:0] w, input int nbits, input int lo,
                           input int hi, input int s_idx, input int s_hi);
    int l;
    int h;
    for (int i = 0; i < nbits; i++) begin
      l = (lo == 0) ? int'($urandom_range(2, 4)) : lo;
      h = (hi == 0) ? int'($urandom_range(2, 4)) : hi;
      if (i == s_idx) h += s_hi;
      for (int k = 0; k < h; k++) tick(1'b1, w[15-i]);
      tick(1'b0, w[15-i]);
      falls.push_back(cyc);
      for (int k = 1; k < l; k++) tick(1'b0, w[15-i]);
    end
  endtask

  // A complete word appears SYNC+1 cycles after the pin fall of its last
  // bit. A partial word followed by idle link is aborted once TIMEOUT_CYC
  // cycles have passed after its last fall became visible, reported the
  // cycle after that.
  task automatic predict(input logic [15:0] w, input int nbits);
    ev_t e;
    int  last;
    last = falls[falls.size()-1];
    if (nbits == DW) begin
      e.cyc  = last + SYNC + 1;
      e.data = w;
      exp_vld.push_back(e);
      exp_fcnt = exp_fcnt + 16'd1;
      exp_data = w;
    end else begin
      exp_err.push_back(last + SYNC + TO + 2);
      if (exp_ecnt < 255) exp_ecnt++;
    end
    falls.delete();
  endtask

  task automatic compare(input string tag);
    chk({tag, " vld count"}, obs_vld.size(), exp_vld.size());
    for (int i = 0; i < exp_vld.size() && i < obs_vld.size(); i++) begin
      chk({tag, " vld cycle"}, obs_vld[i].cyc, exp_vld[i].cyc);
      chk({tag, " vld data"}, obs_vld[i].data, exp_vld[i].data);
    end
    chk({tag, " err count"}, obs_err.size(), exp_err.size());
    for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++) begin
      chk({tag, " err cycle"}, obs_err[i], exp_err[i]);
    end
    chk({tag, " rx_data_o"}, bus.rx_data_o, exp_data);
    chk({tag, " frame_cnt_o"}, bus.frame_cnt_o, exp_fcnt);
    chk({tag, " err_cnt_o"}, bus.err_cnt_o, exp_ecnt);
    chk({tag, " rx_busy_o"}, bus.rx_busy_o, 1'b0);
    exp_vld.delete();
    obs_vld.delete();
    exp_err.delete();
    obs_err.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rx_vld_o"}, bus.rx_vld_o, 1'b0);
    chk({tag, " rx_err_o"}, bus.rx_err_o, 1'b0);
    chk({tag, " rx_busy_o"}, bus.rx_busy_o, 1'b0);
    chk({tag, " rx_data_o"}, bus.rx_data_o, 16'h0);
    chk({tag, " frame_cnt_o"}, bus.frame_cnt_o, 16'h0);
    chk({tag, " err_cnt_o"}, bus.err_cnt_o, 8'h0);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] btb[3];
    btb[0] = 16'h0001;
    btb[1] = 16'h8000;
    btb[2] = 16'hFFFF;

    bus.RX_CLK  = 1'b1;
    bus.RX_DATA = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(IDLE + SYNC + 6);

    send_bits(16'hA5C3, DW, 2, 2, -1, 0);
    predict(16'hA5C3, DW);
    idle(8);
    compare("single A5C3");

    for (int i = 0; i < 3; i++) begin
      send_bits(btb[i], DW, 2, 2, -1, 0);
      predict(btb[i], DW);
    end
    idle(8);
    compare("back-to-back");

    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      send_bits(w, DW, 0, 0, -1, 0);
      predict(w, DW);
      idle(int'($urandom_range(0, 3)));
    end
    idle(8);
    compare("random words");

    send_bits(16'hBEEF, 9, 2, 2, -1, 0);
    predict(16'hBEEF, 9);
    idle(3);
    #1;
    chk("busy mid-word", bus.rx_busy_o, 1'b1);
    idle(TO + SYNC + IDLE + 10);
    compare("truncated");
    send_bits(16'h1234, DW, 2, 2, -1, 0);
    predict(16'h1234, DW);
    idle(8);
    compare("after timeout 1234");

    // Fall spacing of exactly TIMEOUT_CYC+1 cycles: the fall lands on the
    // last tolerated cycle and must win over the timeout.
    send_bits(16'h6E3B, DW, 2, 2, 5, TO + 1 - 4);
    predict(16'h6E3B, DW);
    idle(8);
    compare("fall at timeout");

    send_bits(16'hC3C3, 6, 2, 2, -1, 0);
    falls.delete();
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset mid-word");
    exp_data = '0;
    exp_fcnt = '0;
    exp_ecnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_bits(16'hC3C3 << 6, 10, 2, 2, -1, 0);
    falls.delete();
    idle(IDLE + SYNC + 10);
    compare("after reset tail");
    send_bits(16'h5A5A, DW, 2, 2, -1, 0);
    predict(16'h5A5A, DW);
    idle(8);
    compare("after reset 5A5A");

    force dut.fcnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.fcnt_q;
    exp_fcnt = 16'hFFFF;
    w = 16'($urandom);
    send_bits(w, DW, 0, 0, -1, 0);
    predict(w, DW);
    idle(8);
    compare("frame wrap");

    for (int i = 0; i < 257; i++) begin
      w = 16'($urandom);
      send_bits(w, 1, 2, 2, -1, 0);
      predict(w, 1);
      idle(TO + IDLE + SYNC + 12);
    end
    compare("err saturate");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pmt_communication_rx.md
Name: pmt_communication_rx

Overview:
- Serial receiver paired with the team's pmt_communication_tx link; it sits at the far end of the TX_CLK/TX_DATA pair.
- Oversamples the forwarded link clock and data in its own clk_i domain and deserialises DATA_WIDTH-bit words, MSB first.
- Presents each word as a one-cycle valid pulse, plus framing-error detection and status counters for the downstream register/command decoder.

Parameters:
- DATA_WIDTH, 16: bits per word; must match the transmitter.
- SYNC_STAGES, 2: flip-flop synchroniser depth, applied identically to RX_CLK and RX_DATA; minimum 2.
- TIMEOUT_CYC, 64: clk_i cycles allowed between consecutive falling edges inside a word before the word is aborted.
- IDLE_CYC, 8: consecutive cycles RX_CLK must read high before the receiver arms, after reset or after an error.

Ports:
- clk_i  in  1  receiver clock; must be at least 2x the transmitter clock, so each RX_CLK phase lasts at least 2 clk_i cycles.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- RX_CLK  in  1  link clock; idles high and toggles only while a word is in flight.
- RX_DATA  in  1  link data; MSB first, changes on RX_CLK rising edges and is stable at falling edges.
- rx_vld_o  out  1  one-cycle pulse: rx_data_o holds a new word.
- rx_data_o  out  DATA_WIDTH  last complete word; held until the next word completes.
- rx_err_o  out  1  one-cycle pulse: word aborted on timeout.
- rx_busy_o  out  1  high while a word is partially received (RECV state).
- frame_cnt_o  out  16  good-word count; wraps from 0xFFFF to 0.
- err_cnt_o  out  8  aborted-word count; saturates at 0xFF.

Behaviour:
- Reset values:
  - Synchroniser flops = 1.
  - rx_vld_o = 0, rx_err_o = 0, rx_busy_o = 0.
  - rx_data_o = 0, frame_cnt_o = 0, err_cnt_o = 0.
  - State = ARM.
- Edge detection: fall = synchronised RX_CLK delayed by one cycle is 1 AND current synchronised RX_CLK is 0. RX_DATA uses the same synchroniser depth, so the data bit is taken from its synchronised output in the same cycle as fall.
- Shift register: bit_cnt counts 0..DATA_WIDTH-1. Each captured bit shifts in at the LSB, so the first bit received ends up as the MSB.
- State ARM:
  - idle_cnt increments while synchronised RX_CLK = 1 and clears when it reads 0.
  - When idle_cnt reaches IDLE_CYC, go to IDLE. Falling edges seen while in ARM are ignored.
  - Purpose: a reset released mid-word never produces a false word.
- State IDLE:
  - On fall: capture bit 0, set bit_cnt = 1, clear to_cnt, go to RECV.
- State RECV:
  - On fall: capture the bit, increment bit_cnt, clear to_cnt. Otherwise increment to_cnt.
  - Word complete: when the fall that captures bit DATA_WIDTH-1 occurs, on the next edge drive rx_data_o with the full word, pulse rx_vld_o, increment frame_cnt_o, set bit_cnt = 0, go to IDLE.
  - Timeout: when to_cnt reaches TIMEOUT_CYC, pulse rx_err_o, increment err_cnt_o (saturating), discard the partial word (rx_data_o unchanged), go to ARM.
  - Timeout and fall in the same cycle: fall wins and to_cnt clears.
- Latency: SYNC_STAGES+1 clk_i cycles from the pin-level falling edge of the last bit to rx_vld_o.
- Back-to-back words:
  - The transmitter inserts an idle-high gap of at least 2 clk_i cycles between words.
  - The first fall of the next word is accepted in the same cycle the receiver returns to IDLE, i.e. immediately after completing the previous word.
- Reset asserted mid-word: outputs clear asynchronously, the partial word is lost, and the receiver restarts in ARM.
- Internal counters (bit_cnt, to_cnt, idle_cnt) are sized with $clog2 of their limits; there is no overflow beyond the defined limits.

Test Plan:
- Single word 0xA5C3 sent with the transmitter's timing (phase = 2 clk_i) -> exactly one rx_vld_o pulse with rx_data_o=0xA5C3, SYNC_STAGES+1 cycles after the 16th falling edge; frame_cnt_o=1, rx_err_o never asserted.
- Words 0x0001, 0x8000, 0xFFFF sent back-to-back with a 2-cycle idle gap -> three vld pulses carrying those values in order; frame_cnt_o=3.
- Truncated frame: 9 bits, then RX_CLK held high -> rx_err_o pulses TIMEOUT_CYC cycles after the 9th fall, err_cnt_o=1, no vld, rx_data_o unchanged; a following 0x1234 is received correctly once IDLE_CYC has elapsed.
- rst_n_i pulsed low mid-word while RX_CLK=0 -> all outputs 0 immediately; no vld or err is produced from the remaining bits; next clean word 0x5A5A is received correctly.
- Preload frame_cnt_o to 0xFFFF (force or 65535 words) then send one word -> frame_cnt_o=0x0000; 256 consecutive timeouts -> err_cnt_o=0xFF and remains there on further errors.
- Fall and timeout in the same cycle (fall at to_cnt=TIMEOUT_CYC) -> bit captured, no rx_err_o, word completes normally.
